mem_bus_arbiter: RTL

Parametrised N-master byte-wide memory bus arbiter that sits between the CPU-side masters and the shared synchronous single-port RAM plus the memory-mapped IO window. It generalises the fixed two-source top-level RAM/IO mux to `NUM_MASTERS` requesters. It adds registered read-return routing, bounded burst locking, IO write backpressure and an external hold used while the host interface owns memory.

---
 rtl/mem_bus_pkg.sv | 12 +
 rtl/mem_bus_rr_pick.sv | 27 ++
 rtl/mem_bus_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared constants and helpers for the memory bus arbiter.
package mem_bus_pkg;

    localparam logic [1:0] IO_WINDOW    = 2'b11;
    localparam int         IO_SEL_WIDTH = 3;

    // Master-ID width, never narrower than one bit.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_bus_rr_pick.sv
// Rotate-and-priority-encode: first eligible master at or after ptr, returned one-hot.
module mem_bus_rr_pick #(
    parameter int N    = 2,
    parameter int ID_W = 1
) (
    input  logic [N-1:0]    elig,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    pick
);

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = ID_W'((int'(ptr) + k) % N);
            if (!found && elig[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// N-master arbiter for the shared RAM and IO window with burst locking and 1-cycle read return.
// Define MEM_BUS_RR_EN for round-robin selection; otherwise the lowest eligible index wins.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int DATA_WIDTH     = 8,
    parameter int MAX_BURST      = 4
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic                              hold_in,
    input  logic [NUM_MASTERS-1:0]            m_req_in,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_in,
    input  logic [NUM_MASTERS-1:0]            m_wr_in,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_in,
    output logic [NUM_MASTERS-1:0]            m_gnt_out,
    output logic [NUM_MASTERS-1:0]            m_rvalid_out,
    output logic [DATA_WIDTH-1:0]             m_rdata_out,
    output logic [RAM_ADDR_WIDTH-1:0]         ram_addr_out,
    output logic                              ram_we_out,
    output logic [DATA_WIDTH-1:0]             ram_wdata_out,
    input  logic [DATA_WIDTH-1:0]             ram_rdata_in,
    output logic                              io_en_out,
    output logic [IO_SEL_WIDTH-1:0]           io_sel_out,
    output logic                              io_wr_out,
    output logic [DATA_WIDTH-1:0]             io_wdata_out,
    input  logic [DATA_WIDTH-1:0]             io_rdata_in,
    input  logic                              io_full_in
);

    // Handshake: an access is accepted in the cycle m_req_in[i] & m_gnt_out[i]; a read then
    // returns exactly one cycle later as m_rvalid_out[i] with m_rdata_out, never back-pressured.

    localparam int              ID_W    = id_width(NUM_MASTERS);
    localparam int              CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

    logic [NUM_MASTERS-1:0]    is_io;
    logic [NUM_MASTERS-1:0]    elig;
    logic [NUM_MASTERS-1:0]    owner_mask;
    logic [NUM_MASTERS-1:0]    pick;
    logic [NUM_MASTERS-1:0]    gnt;
    logic                      lock_valid;
    logic [ID_W-1:0]           lock_owner;
    logic [CNT_W-1:0]          burst_cnt;
    logic                      owner_elig;
    logic                      contender;
    logic                      keep;
    logic                      any_gnt;
    logic [ID_W-1:0]           gnt_idx;
    logic [RAM_ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]     sel_wdata;
    logic                      sel_wr;
    logic                      sel_io;
    logic                      rd_pending;
    logic [ID_W-1:0]           rd_owner;
    logic                      rd_is_io;
    logic                      unused_addr_hi;

    assign unused_addr_hi = ^m_addr_in;

    // Gating with rst_n_in keeps every output quiet while reset is asserted.
    always_comb begin
        is_io      = '0;
        elig       = '0;
        owner_mask = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            is_io[i]      = (m_addr_in[i*ADDR_WIDTH + RAM_ADDR_WIDTH -: 2] == IO_WINDOW);
            elig[i]       = rst_n_in & m_req_in[i] & ~hold_in
                          & ~(m_wr_in[i] & is_io[i] & io_full_in);
            owner_mask[i] = (lock_owner == ID_W'(i));
        end
    end

    // The owner only yields at the burst cap when someone else is actually waiting.
    assign owner_elig = |(elig & owner_mask);
    assign contender  = |(elig & ~owner_mask);
    assign keep       = lock_valid & owner_elig & ((burst_cnt < CNT_MAX) | ~contender);
    assign gnt        = keep ? (elig & owner_mask) : pick;
    assign any_gnt    = |gnt;

`ifdef MEM_BUS_RR_EN
    logic [ID_W-1:0] rr_ptr;

    mem_bus_rr_pick #(
        .N    (NUM_MASTERS),
        .ID_W (ID_W)
    ) u_rr_pick (
        .elig (elig),
        .ptr  (rr_ptr),
        .pick (pick)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rr_ptr <= '0;
        end else if (any_gnt && !keep) begin
            rr_ptr <= (gnt_idx == ID_W'(NUM_MASTERS - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
`else
    always_comb begin
        pick = '0;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (elig[i]) pick = NUM_MASTERS'(1) << i;
        end
    end
`endif

    always_comb begin
        gnt_idx   = '0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wr    = 1'b0;
        sel_io    = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (gnt[i]) begin
                gnt_idx   = ID_W'(i);
                sel_addr  = m_addr_in[i*ADDR_WIDTH +: RAM_ADDR_WIDTH];
                sel_wdata = m_wdata_in[i*DATA_WIDTH +: DATA_WIDTH];
                sel_wr    = m_wr_in[i];
                sel_io    = is_io[i];
            end
        end
    end

    assign m_gnt_out     = gnt;
    assign ram_addr_out  = sel_addr;
    assign ram_we_out    = any_gnt & sel_wr & ~sel_io;
    assign ram_wdata_out = sel_wdata;
    assign io_en_out     = ~hold_in & sel_io & any_gnt;
    assign io_wr_out     = io_en_out & sel_wr;
    assign io_sel_out    = sel_addr[IO_SEL_WIDTH-1:0];
    assign io_wdata_out  = sel_wdata;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            lock_valid <= 1'b0;
            lock_owner <= '0;
            burst_cnt  <= '0;
            rd_pending <= 1'b0;
            rd_owner   <= '0;
            rd_is_io   <= 1'b0;
        end else begin
            lock_valid <= any_gnt;
            if (keep) begin
                if (burst_cnt != CNT_MAX) burst_cnt <= burst_cnt + 1'b1;
            end else if (any_gnt) begin
                lock_owner <= gnt_idx;
                burst_cnt  <= CNT_W'(1);
            end
            rd_pending <= any_gnt & ~sel_wr;
            rd_owner   <= gnt_idx;
            rd_is_io   <= sel_io;
        end
    end

    always_comb begin
        m_rvalid_out = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_rvalid_out[i] = rd_pending & (rd_owner == ID_W'(i));
        end
    end

    assign m_rdata_out = !rd_pending ? '0 : (rd_is_io ? io_rdata_in : ram_rdata_in);

endmodule
